// File: rtl/icache_axi_pkg.sv
// Shared types and AXI constants for the icache AXI read bridge.
package icache_axi_pkg;

  localparam int unsigned LINE_WORDS = 16;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StAr,
    StR
  } state_e;

endpackage

// File: rtl/axi_r_beat_checker.sv
// Counts R beats of a line refill and flags rid/rresp/rlast violations in a sticky bus_err.
module axi_r_beat_checker #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned LINE_WORDS = 16,
  parameter int unsigned CNT_WIDTH  = $clog2(LINE_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 hs,
  input  logic [ID_WIDTH-1:0]  rid,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  output logic [CNT_WIDTH-1:0] beat_cnt,
  output logic                 bus_err
);
  import icache_axi_pkg::*;

  logic last_beat;
  logic beat_err;

  assign last_beat = (beat_cnt == CNT_WIDTH'(LINE_WORDS - 1));

  // rlast must agree with the local count in both directions.
  assign beat_err = (rresp != RESP_OKAY) || (rid != ID_WIDTH'(AXI_ID)) || (rlast != last_beat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (clr) begin
        beat_cnt <= '0;
      end else if (hs) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (hs && beat_err) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/icache_axi_rd_bridge.sv
// Turns icache line-refill requests into single AXI4 INCR read bursts of one line.
// Optional perf counters are enabled by defining ICACHE_AXI_PERF_EN.
module icache_axi_rd_bridge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 16,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned ADDR_ALIGN = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_iaddr_req,
  input  logic [31:0]           mem_addr,
  output logic                  mem_iaddr_ok,
  output logic                  mem_idata_ok,
  output logic [DATA_WIDTH-1:0] mem_inst_rdata,
  output logic                  mem_idata_rlast,
  output logic [ID_WIDTH-1:0]   arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
`ifdef ICACHE_AXI_PERF_EN
  output logic [31:0]           perf_req_cnt,
  output logic [31:0]           perf_lat_cyc,
`endif
  output logic                  bus_err
);
  import icache_axi_pkg::*;

  localparam int unsigned CntW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  state_e                state_q, state_d;
  logic [31:0]           araddr_d;
  logic                  arvalid_d;
  logic                  rready_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CntW-1:0]       beat_cnt;
  logic                  ar_hs;
  logic                  hs;
  logic                  last_beat;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^mem_addr[ADDR_ALIGN-1:0];

  assign arid    = ID_WIDTH'(AXI_ID);
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;

  assign ar_hs     = arvalid & arready;
  assign hs        = rvalid & rready;
  assign last_beat = (beat_cnt == CntW'(LINE_WORDS - 1));

  assign mem_iaddr_ok    = ar_hs;
  assign mem_idata_ok    = hs;
  assign mem_idata_rlast = hs & last_beat;
  assign mem_inst_rdata  = hs ? rdata : rdata_q;

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr;
    arvalid_d = arvalid;
    rready_d  = rready;
    unique case (state_q)
      StIdle: begin
        if (mem_iaddr_req) begin
          araddr_d  = {mem_addr[31:ADDR_ALIGN], {ADDR_ALIGN{1'b0}}};
          arvalid_d = 1'b1;
          state_d   = StAr;
        end
      end
      StAr: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StR;
        end
      end
      StR: begin
        if (hs && last_beat) begin
          rready_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      araddr  <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      araddr  <= araddr_d;
      arvalid <= arvalid_d;
      rready  <= rready_d;
      if (hs) begin
        rdata_q <= rdata;
      end
    end
  end

  axi_r_beat_checker #(
    .ID_WIDTH   (ID_WIDTH),
    .AXI_ID     (AXI_ID),
    .LINE_WORDS (LINE_WORDS),
    .CNT_WIDTH  (CntW)
  ) u_checker (
    .clk      (clk),
    .rst      (rst),
    .clr      (ar_hs),
    .hs       (hs),
    .rid      (rid),
    .rresp    (rresp),
    .rlast    (rlast),
    .beat_cnt (beat_cnt),
    .bus_err  (bus_err)
  );

`ifdef ICACHE_AXI_PERF_EN
  logic [31:0] req_cnt_q;
  logic [31:0] lat_cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_cnt_q <= '0;
      lat_cyc_q <= '0;
    end else begin
      if (ar_hs && (req_cnt_q != '1)) begin
        req_cnt_q <= req_cnt_q + 1'b1;
      end
      if ((state_q != StIdle) && (lat_cyc_q != '1)) begin
        lat_cyc_q <= lat_cyc_q + 1'b1;
      end
    end
  end

  assign perf_req_cnt = req_cnt_q;
  assign perf_lat_cyc = lat_cyc_q;
`endif

endmodule
